// File: rtl/apb_reg_block_1.sv
// apb_reg_block_1: APB slave front-end and seven 32-bit registers on one clock.
// Software writes come in over APB. Hardware writes come in on per-register
// pulse ports. Per-register sync resets and access strobes are also provided.
module apb_reg_block_1 #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  fsm_clk,
  input  logic                  fsm_rst,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] PRDATA,
  input  logic [DATA_WIDTH-1:0] reg1_next_value,
  input  logic [DATA_WIDTH-1:0] reg2_next_value,
  input  logic [DATA_WIDTH-1:0] reg3_next_value,
  input  logic [DATA_WIDTH-1:0] reg4_next_value,
  input  logic [DATA_WIDTH-1:0] reg5_next_value,
  input  logic [DATA_WIDTH-1:0] reg6_next_value,
  input  logic [DATA_WIDTH-1:0] reg7_next_value,
  input  logic                  reg1_pulse,
  input  logic                  reg2_pulse,
  input  logic                  reg3_pulse,
  input  logic                  reg4_pulse,
  input  logic                  reg5_pulse,
  input  logic                  reg6_pulse,
  input  logic                  reg7_pulse,
  output logic [DATA_WIDTH-1:0] reg1_curr_value,
  output logic [DATA_WIDTH-1:0] reg2_curr_value,
  output logic [DATA_WIDTH-1:0] reg3_curr_value,
  output logic [DATA_WIDTH-1:0] reg4_curr_value,
  output logic [DATA_WIDTH-1:0] reg5_curr_value,
  output logic [DATA_WIDTH-1:0] reg6_curr_value,
  output logic [DATA_WIDTH-1:0] reg7_curr_value,
  input  logic                  srst_1,
  input  logic                  srst_2,
  input  logic                  srst_3,
  input  logic                  srst_4,
  input  logic                  srst_5,
  input  logic                  global_sync_reset_in,
  output logic                  swmod_out,
  output logic                  swacc_out
);

  localparam int NumRegs = 7;

  // Index 0 is REG1. The concatenation below lists REG7 first.
  localparam logic [NumRegs-1:0][DATA_WIDTH-1:0] ResetValue = {
    32'hDEAD_BEEF, 32'h0000_00FF, 32'h8000_0000, 32'h0000_0001,
    32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h0000_0000
  };

  // Only REG7 lets a hardware write beat a same-edge software write.
  localparam logic [NumRegs-1:0] HwPrecedence = 7'b100_0000;

  localparam logic [2:0] Reg4Idx = 3'd3;
  localparam logic [2:0] Reg5Idx = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StReady
  } apbState_e;

  apbState_e                            state_q, state_d;
  logic      [DATA_WIDTH-1:0]           rdata_q, rdata_d;
  logic                                 err_q, err_d;
  logic      [NumRegs-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic      [NumRegs-1:0][DATA_WIDTH-1:0] hwNext;
  logic      [NumRegs-1:0]              hwPulse;
  logic      [NumRegs-1:0]              syncRst;
  logic                                 addrHit;
  logic      [2:0]                      addrIdx;
  logic                                 swAccess;
  logic                                 swWr;

  assign hwNext = {reg7_next_value, reg6_next_value, reg5_next_value, reg4_next_value,
                   reg3_next_value, reg2_next_value, reg1_next_value};
  assign hwPulse = {reg7_pulse, reg6_pulse, reg5_pulse, reg4_pulse,
                    reg3_pulse, reg2_pulse, reg1_pulse};
  assign syncRst = {4'b0000, global_sync_reset_in,
                    srst_3 | srst_4 | srst_5,
                    srst_1 | srst_2 | srst_3};

  // Address decode. Each register has an exact full-width byte address at 4*index.
  always_comb begin
    addrHit = 1'b0;
    addrIdx = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (PADDR == ADDR_WIDTH'(4 * i)) begin
        addrHit = 1'b1;
        addrIdx = 3'(i);
      end
    end
  end

  // The software access strobe fires only in the first access cycle after a setup.
  assign swAccess = (state_q == StSetup) && PSEL && PENABLE;
  assign swWr     = swAccess && PWRITE && addrHit;

  // APB front-end next state. Read data and the error flag are captured at the access edge.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (PSEL && !PENABLE) state_d = StSetup;
      end
      StSetup: begin
        if (!PSEL) begin
          state_d = StIdle;
        end else if (PENABLE) begin
          state_d = StReady;
          err_d   = !addrHit;
          rdata_d = (!PWRITE && addrHit) ? regs_q[addrIdx] : '0;
        end
      end
      StReady: begin
        if (!PSEL)         state_d = StIdle;
        else if (!PENABLE) state_d = StSetup;
      end
      default: state_d = StIdle;
    endcase
  end

  // Front-end state and response registers. They go idle and clear on async reset.
  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      state_q <= StIdle;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Per-register update, in priority order: sync reset, winning write, other write, hold.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NumRegs; i++) begin
      if (syncRst[i]) begin
        regs_d[i] = ResetValue[i];
      end else if (HwPrecedence[i] && hwPulse[i]) begin
        regs_d[i] = hwNext[i];
      end else if (swWr && (addrIdx == 3'(i))) begin
        regs_d[i] = PWDATA;
      end else if (hwPulse[i]) begin
        regs_d[i] = hwNext[i];
      end
    end
  end

  // Register file flops. Async reset loads every reset value immediately.
  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      regs_q <= ResetValue;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign PREADY  = (state_q == StReady) && PSEL;
  assign PSLVERR = PREADY && err_q;
  assign PRDATA  = PREADY ? rdata_q : '0;

  assign swmod_out = swWr && (addrIdx == Reg4Idx);
  assign swacc_out = swAccess && addrHit && (addrIdx == Reg5Idx);

  assign reg1_curr_value = regs_q[0];
  assign reg2_curr_value = regs_q[1];
  assign reg3_curr_value = regs_q[2];
  assign reg4_curr_value = regs_q[3];
  assign reg5_curr_value = regs_q[4];
  assign reg6_curr_value = regs_q[5];
  assign reg7_curr_value = regs_q[6];

endmodule

// File: tb/tb_apb_reg_block_1.sv
// tb_apb_reg_block_1: scoreboard bench for apb_reg_block_1.
// Random APB and hardware traffic is checked against a simple register-array model.
module tb_apb_reg_block_1;

  logic        fsmClk = 1'b0;
  logic        fsmRst;
  logic        psel, penable, pwrite;
  logic [63:0] paddr;
  logic [31:0] pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [31:0] nextVal [7];
  logic        pulse [7];
  logic [31:0] currVal [7];
  logic [5:1]  srst;
  logic        globalSrst;
  logic        swmod, swacc;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic [31:0] resetVal [7] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h0000_0001,
                                32'h8000_0000, 32'h0000_00FF, 32'hDEAD_BEEF};
  logic [63:0] badAddr [5] = '{64'h40, 64'h1C, 64'h2, 64'h1_0000_0004, 64'hFFFF_FFFF_FFFF_FFF0};
  logic [31:0] model [7];
  resp_t       expQ [$];
  int          nCompared = 0;
  int          nMismatched = 0;
  logic        preadyPrev = 1'b0;

  apb_reg_block_1 dut (
    .fsm_clk(fsmClk), .fsm_rst(fsmRst),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PREADY(pready), .PSLVERR(pslverr), .PRDATA(prdata),
    .reg1_next_value(nextVal[0]), .reg2_next_value(nextVal[1]), .reg3_next_value(nextVal[2]),
    .reg4_next_value(nextVal[3]), .reg5_next_value(nextVal[4]), .reg6_next_value(nextVal[5]),
    .reg7_next_value(nextVal[6]),
    .reg1_pulse(pulse[0]), .reg2_pulse(pulse[1]), .reg3_pulse(pulse[2]), .reg4_pulse(pulse[3]),
    .reg5_pulse(pulse[4]), .reg6_pulse(pulse[5]), .reg7_pulse(pulse[6]),
    .reg1_curr_value(currVal[0]), .reg2_curr_value(currVal[1]), .reg3_curr_value(currVal[2]),
    .reg4_curr_value(currVal[3]), .reg5_curr_value(currVal[4]), .reg6_curr_value(currVal[5]),
    .reg7_curr_value(currVal[6]),
    .srst_1(srst[1]), .srst_2(srst[2]), .srst_3(srst[3]), .srst_4(srst[4]), .srst_5(srst[5]),
    .global_sync_reset_in(globalSrst),
    .swmod_out(swmod), .swacc_out(swacc)
  );

  // 100 MHz clock.
  always #5 fsmClk = ~fsmClk;

  // Record one comparison, and report it if the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Map a byte address to a register index, or -1 if no register lives there.
  function automatic int regIdx(input logic [63:0] addr);
    for (int i = 0; i < 7; i++) begin
      if (addr == 64'(4 * i)) return i;
    end
    return -1;
  endfunction

  // Monitor. Each new PREADY pops one expected response and checks the bus against it.
  always @(negedge fsmClk) begin : monitor
    resp_t e;
    if (pready && !preadyPrev) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pready", 32'(pready), 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("prdata", prdata, e.rdata);
        checkOutput("pslverr", 32'(pslverr), 32'(e.err));
      end
    end
    preadyPrev = pready;
  end

  // Compare every register's current value with the model.
  task automatic checkRegs(input string tag);
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("%s_reg%0d", tag, i + 1), currVal[i], model[i]);
    end
  endtask

  // Run one APB transfer. An optional hardware write can land on the access edge.
  task automatic applyStimulus(input bit write, input logic [63:0] addr, input logic [31:0] data,
                               input int hwIdx, input logic [31:0] hwData);
    int    idx;
    int    waited;
    resp_t e;
    idx     = regIdx(addr);
    e.err   = (idx < 0);
    e.rdata = (!write && idx >= 0) ? model[idx] : 32'd0;
    expQ.push_back(e);

    @(posedge fsmClk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = write; paddr = addr; pwdata = data;
    @(negedge fsmClk);
    checkOutput("swmod_setup", 32'(swmod), 32'd0);
    checkOutput("swacc_setup", 32'(swacc), 32'd0);

    @(posedge fsmClk); #1;
    penable = 1'b1;
    if (hwIdx >= 0) begin
      nextVal[hwIdx] = hwData;
      pulse[hwIdx]   = 1'b1;
    end
    @(negedge fsmClk);
    checkOutput("swmod_access", 32'(swmod), 32'(write && idx == 3));
    checkOutput("swacc_access", 32'(swacc), 32'(idx == 4));

    // Both writes land on the same edge. Only REG7 lets the hardware write win.
    if (hwIdx >= 0) model[hwIdx] = hwData;
    if (write && idx >= 0 && !(idx == 6 && hwIdx == 6)) model[idx] = data;

    @(posedge fsmClk); #1;
    if (hwIdx >= 0) pulse[hwIdx] = 1'b0;
    waited = 0;
    while (!pready && waited < 8) begin
      @(posedge fsmClk); #1;
      waited++;
    end
    if (!pready) begin
      checkOutput("pready_timeout", 32'd0, 32'd1);
      void'(expQ.pop_back());
    end else begin
      @(negedge fsmClk);
      checkOutput("swmod_ready", 32'(swmod), 32'd0);
      checkOutput("swacc_ready", 32'(swacc), 32'd0);
    end
    @(posedge fsmClk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // One cycle of hardware pulses and sync resets. A sync reset overrides a pulse.
  // smask bits 0..4 are srst_1..srst_5; bit 5 is the global sync reset.
  task automatic applyHwCycle(input logic [6:0] pmask, input logic [5:0] smask, input bit randData,
                              input logic [31:0] data);
    bit hit [7];
    @(posedge fsmClk); #1;
    for (int i = 0; i < 7; i++) begin
      nextVal[i] = randData ? $urandom : data;
      pulse[i]   = pmask[i];
    end
    srst = smask[4:0];
    globalSrst = smask[5];
    hit[0] = smask[0] || smask[1] || smask[2];
    hit[1] = smask[2] || smask[3] || smask[4];
    hit[2] = smask[5];
    for (int i = 3; i < 7; i++) hit[i] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (hit[i])        model[i] = resetVal[i];
      else if (pmask[i]) model[i] = nextVal[i];
    end
    @(posedge fsmClk); #1;
    for (int i = 0; i < 7; i++) pulse[i] = 1'b0;
    srst = '0;
    globalSrst = 1'b0;
  endtask

  // Pulse the async reset away from any clock edge. Check the values within 2 ns.
  task automatic applyReset();
    @(posedge fsmClk); #2;
    fsmRst = 1'b1;
    for (int i = 0; i < 7; i++) model[i] = resetVal[i];
    #2;
    checkRegs("async_rst");
    checkOutput("rst_pready", 32'(pready), 32'd0);
    checkOutput("rst_pslverr", 32'(pslverr), 32'd0);
    checkOutput("rst_prdata", prdata, 32'd0);
    checkOutput("rst_swmod", 32'(swmod), 32'd0);
    checkOutput("rst_swacc", 32'(swacc), 32'd0);
    @(posedge fsmClk); #1;
    fsmRst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed cases first, then randomized traffic.
  initial begin
    int          hwIdx;
    logic [63:0] addr;
    logic [5:0]  smask;
    fsmRst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    srst = '0; globalSrst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      nextVal[i] = '0;
      pulse[i]   = 1'b0;
      model[i]   = resetVal[i];
    end
    repeat (2) @(posedge fsmClk);
    #1;
    checkRegs("reset");
    checkOutput("reset_pready", 32'(pready), 32'd0);
    fsmRst = 1'b0;

    // Read REG3 after reset, then write to an unmapped address.
    applyStimulus(1'b0, 64'h08, 32'h0, -1, 32'h0);
    applyStimulus(1'b1, 64'h40, 32'hFFFF_0000, -1, 32'h0);
    checkRegs("unmapped_wr");

    // Write every register, then reset asynchronously.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 64'(4 * i), 32'h1234_5678, -1, 32'h0);
    checkRegs("sw_write_all");
    applyReset();

    // Hardware-write every register, then apply each sync reset source alone.
    for (int k = 0; k < 6; k++) begin
      applyHwCycle(7'h7F, 6'h00, 1'b0, 32'h1234_5678);
      applyHwCycle(7'h00, 6'(1 << k), 1'b0, 32'h0);
      checkRegs($sformatf("srst%0d", k + 1));
    end

    // Same-edge precedence: REG6 goes to software, REG7 to hardware.
    applyStimulus(1'b1, 64'h14, 32'h1234_5678, 5, 32'h8765_4321);
    checkOutput("prec_reg6", currVal[5], 32'h1234_5678);
    applyStimulus(1'b1, 64'h18, 32'h1234_5678, 6, 32'h8765_4321);
    checkOutput("prec_reg7", currVal[6], 32'h8765_4321);

    // Strobe checks for REG4 and REG5 accesses.
    applyStimulus(1'b1, 64'h0C, 32'h0000_0042, -1, 32'h0);
    applyStimulus(1'b0, 64'h10, 32'h0, -1, 32'h0);
    applyStimulus(1'b1, 64'h10, 32'h0000_0055, -1, 32'h0);
    checkRegs("strobes");

    // Async reset in the middle of an access cycle aborts the transfer.
    @(posedge fsmClk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 64'h0; pwdata = 32'hCAFE_F00D;
    @(posedge fsmClk); #1;
    penable = 1'b1;
    #1 fsmRst = 1'b1;
    for (int i = 0; i < 7; i++) model[i] = resetVal[i];
    #2 fsmRst = 1'b0;
    repeat (3) begin
      @(negedge fsmClk);
      checkOutput("abort_pready", 32'(pready), 32'd0);
    end
    @(posedge fsmClk); #1;
    psel = 1'b0; penable = 1'b0;
    checkRegs("abort");

    // Randomized mix of APB transfers and hardware/sync-reset cycles.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 2) begin
        smask = ($urandom_range(0, 2) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'h00;
        applyHwCycle(7'($urandom), smask, 1'b1, 32'h0);
        checkRegs("rand_hw");
      end else begin
        addr  = ($urandom_range(0, 7) == 0) ? badAddr[$urandom_range(0, 4)]
                                            : 64'(4 * $urandom_range(0, 6));
        hwIdx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
        applyStimulus(1'($urandom_range(0, 1)), addr, $urandom, hwIdx, $urandom);
        checkRegs("rand_apb");
      end
    end

    repeat (3) @(posedge fsmClk);
    #1;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/apb_reg_block_1.md
Name: apb_reg_block_1

Overview:
- APB-slave register block holding seven 32-bit software/hardware-accessible registers (REG1..REG7), each with a hardware write port and a current-value output.
- Integrates the APB front-end and the register file on a single clock.
- Exercises async and sync resets, reset values, swmod/swacc strobes and sw/hw write precedence.
- Sits directly under the system APB interconnect.

Parameters:
ADDR_WIDTH, 64, APB address width.
DATA_WIDTH, 32, APB data and register width.

Ports:
fsm_clk  in  1  single clock (APB and registers).
fsm_rst  in  1  asynchronous active-high reset.
PSEL  in  1  APB select.
PENABLE  in  1  APB enable.
PWRITE  in  1  APB write (1) / read (0).
PADDR  in  ADDR_WIDTH  byte address.
PWDATA  in  DATA_WIDTH  write data.
PREADY  out  1  transfer complete.
PSLVERR  out  1  error response.
PRDATA  out  DATA_WIDTH  read data.
regN_next_value  in  32  hw write data, for N=1..7.
regN_pulse  in  1  hw write strobe, for N=1..7.
regN_curr_value  out  32  current register content, for N=1..7.
srst_1..srst_5  in  1 each  field sync resets.
global_sync_reset_in  in  1  block-level sync reset.
swmod_out  out  1  REG4 software-modify strobe.
swacc_out  out  1  REG5 software-access strobe.

Behaviour:
- Address map, exact 64-bit byte address match, DATA_WIDTH-aligned:
  - REG1 0x00, REG2 0x04, REG3 0x08, REG4 0x0C, REG5 0x10, REG6 0x14, REG7 0x18.
- Reset values:
  - REG1 0x0000_0000, REG2 0xFFFF_FFFF, REG3 0xA5A5_A5A5, REG4 0x0000_0001.
  - REG5 0x8000_0000, REG6 0x0000_00FF, REG7 0xDEAD_BEEF.
- fsm_rst high (async):
  - All registers load their reset values immediately, without waiting for a clock edge.
  - PREADY, PSLVERR, swmod_out, swacc_out = 0; PRDATA = 0.
- APB protocol:
  - Setup cycle: PSEL=1, PENABLE=0.
  - First access cycle: PSEL=1, PENABLE=1. An internal sw_wr (write) or sw_rd (read) strobe is high for exactly this one cycle; the selected register updates at the closing fsm_clk edge.
  - PREADY=1 in the following cycle (one wait state) and is held until PSEL drops; it is then cleared.
  - Reads: PRDATA carries the register value while PREADY=1.
  - Unmapped address: PREADY with PSLVERR=1; PRDATA=0; no register changes.
  - PSEL low returns the front-end to idle. A new setup may start the cycle after completion.
- Register update priority, evaluated per fsm_clk edge:
  - 1. Sync reset to the reset value (highest).
  - 2. Precedence-winning write.
  - 3. The other write.
  - 4. Hold.
- Sync reset sources:
  - REG1: srst_1 | srst_2 | srst_3.
  - REG2: srst_3 | srst_4 | srst_5.
  - REG3: global_sync_reset_in.
  - REG4..REG7: none.
- Hardware write: regN_pulse=1 at an edge loads regN_next_value.
- Software write: sw_wr to the register loads PWDATA.
- Simultaneous sw and hw write (same edge):
  - REG1..REG6 software precedence: PWDATA wins, hw write discarded.
  - REG7 hardware precedence: next_value wins, sw write discarded.
- swmod_out = sw_wr to REG4 (combinational, one-cycle pulse). Reads do not assert it.
- swacc_out = (sw_wr | sw_rd) to REG5, one-cycle pulse.
- regN_curr_value is continuously the register flop output.
- Reset asserted mid-transfer: transfer aborted, front-end idle, no PREADY until a new setup phase.

Test Plan:
- Reset/write: after reset release, APB-write 0x12345678 to each REG1..REG7. Required: curr_value = 0x12345678 one cycle after PREADY. Then pulse fsm_rst. Required: within 2 ns curr_value equals that register's reset value.
- Hw write + sync reset: pulse reg1_pulse with 0x12345678, then hold srst_1 for one cycle. Required: REG1 = 0x0000_0000. Repeat the same for srst_2 and srst_3 (srst_3 also clears REG2 to 0xFFFF_FFFF), and for srst_4/srst_5 on REG2. Required: unaffected registers keep 0x12345678.
- Precedence: raise reg6_pulse with 0x87654321 in the same cycle as the REG6 sw_wr of 0x12345678. Required: REG6 = 0x12345678. Same stimulus on REG7. Required: REG7 = 0x87654321.
- Strobes: write REG4. Required: swmod_out high exactly 1 cycle; swacc_out stays 0. Read and write REG5. Required: swacc_out high exactly 1 cycle each access; swmod_out stays 0.
- Read/error: read REG3 after reset. Required: PRDATA = 0xA5A5A5A5, PSLVERR=0. Write to 0x40. Required: PSLVERR=1, no register changes.
